// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
//   Shared constants and types for the direct-mapped instruction cache.
//   Contents:
//     TRUE/FALSE        single-bit logic constants
//     DEF_INDEX_BITS    default index width (lines = 2**INDEX_BITS)
//     DEF_ADDR_BITS     default number of significant address bits
//     WORD_W / BYTE_W   cache word and memory-port byte-lane widths
//     BEAT_W            width of the refill beat counter (4 beats per line)
//     state_e           cache controller states
//     insert_byte()     drops one byte into a selected lane of a word
// -----------------------------------------------------------------------------
package icache_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam int DEF_INDEX_BITS = 6;
   localparam int DEF_ADDR_BITS  = 18;

   localparam int WORD_W = 32;
   localparam int BYTE_W = 8;
   localparam int BEAT_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Little-endian assembly: lane 0 is bits [7:0], lane 3 is bits [31:24].
   function automatic logic [WORD_W-1:0] insert_byte(
      input logic [WORD_W-1:0] word,
      input logic [BEAT_W-1:0] lane,
      input logic [BYTE_W-1:0] data
   );
      logic [WORD_W-1:0] result;
      result = word;
      result[lane*BYTE_W +: BYTE_W] = data;
      return result;
   endfunction

endpackage

// File: rtl/icache_array.sv
// -----------------------------------------------------------------------------
// icache_array
//   Tag/data/valid storage for the direct-mapped instruction cache.
//   One line holds one 32-bit word. Reads are combinational by index so a
//   hit can be latched into the response register in the request cycle.
//   Ports:
//     clk          system clock
//     rst          asynchronous active-low reset; clears every valid bit
//     rd_index_i   line selected for lookup
//     rd_valid_o   valid bit of the selected line
//     rd_tag_o     stored tag of the selected line
//     rd_data_o    stored word of the selected line
//     wr_en_i      write strobe (refill completion only)
//     wr_index_i   line to write
//     wr_tag_i     tag written with the line
//     wr_data_i    word written with the line
// -----------------------------------------------------------------------------
module icache_array
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = DEF_INDEX_BITS,
   parameter int TAG_BITS   = DEF_ADDR_BITS - DEF_INDEX_BITS - 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] rd_index_i,
   output logic                  rd_valid_o,
   output logic [TAG_BITS-1:0]   rd_tag_o,
   output logic [WORD_W-1:0]     rd_data_o,
   input  logic                  wr_en_i,
   input  logic [INDEX_BITS-1:0] wr_index_i,
   input  logic [TAG_BITS-1:0]   wr_tag_i,
   input  logic [WORD_W-1:0]     wr_data_i
);

   localparam int LINES = 1 << INDEX_BITS;

   logic                valid_q  [LINES];
   logic [TAG_BITS-1:0] tag_mem  [LINES];
   logic [WORD_W-1:0]   data_mem [LINES];

   // Valid bits are the only state that needs a reset: tag and data of an
   // invalid line are never trusted, so they live in plain storage.
   genvar gi;
   generate
      for (gi = 0; gi < LINES; gi++) begin : g_valid
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               valid_q[gi] <= FALSE;
            end else if (wr_en_i && (wr_index_i == INDEX_BITS'(gi))) begin
               valid_q[gi] <= TRUE;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         tag_mem[wr_index_i]  <= wr_tag_i;
         data_mem[wr_index_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_tag_o   = tag_mem[rd_index_i];
   assign rd_data_o  = data_mem[rd_index_i];

endmodule

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
//   Direct-mapped instruction cache between the instruction fetcher and the
//   memory controller. Hits answer one cycle after the request is sampled;
//   misses refill the line byte-serially (little-endian, 4 beats) and answer
//   one cycle after the last beat. clr aborts the current request without
//   touching the array; rdy=0 freezes every register.
//   Ports:
//     clk          system clock
//     rst          asynchronous active-low reset
//     rdy          global ready; low freezes all state
//     clr          flush; abort the in-flight request
//     addr         fetch byte address ([1:0] ignored)
//     rn           read request, held by the fetcher until Read_ready
//     Inst         instruction word, valid while Read_ready=1
//     Read_ready   one-cycle response pulse
//     mem_a        byte address to the memory controller
//     mem_rn       byte read request to the memory controller
//     mem_din      byte returned for mem_a
//     mem_valid    mem_din valid this cycle
// -----------------------------------------------------------------------------
module icache
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = DEF_INDEX_BITS,
   parameter int ADDR_BITS  = DEF_ADDR_BITS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clr,
   input  logic [31:0]       addr,
   input  logic              rn,
   output logic [WORD_W-1:0] Inst,
   output logic              Read_ready,
   output logic [31:0]       mem_a,
   output logic              mem_rn,
   input  logic [BYTE_W-1:0] mem_din,
   input  logic              mem_valid
);

   localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

   state_e                state_q,      state_d;
   logic [WORD_W-1:0]     inst_q,       inst_d;
   logic                  read_ready_q, read_ready_d;
   logic [31:0]           mem_a_q,      mem_a_d;
   logic                  mem_rn_q,     mem_rn_d;
   logic [BEAT_W-1:0]     beat_q,       beat_d;
   logic [WORD_W-1:0]     fill_word_q,  fill_word_d;
   logic [INDEX_BITS-1:0] req_index_q,  req_index_d;
   logic [TAG_BITS-1:0]   req_tag_q,    req_tag_d;

   logic [INDEX_BITS-1:0] addr_index;
   logic [TAG_BITS-1:0]   addr_tag;
   logic                  line_valid;
   logic [TAG_BITS-1:0]   line_tag;
   logic [WORD_W-1:0]     line_data;
   logic                  hit;
   logic [WORD_W-1:0]     assembled;
   logic                  fill_done;
   logic                  wr_en;
   logic                  unused_addr_bits;

   assign addr_index       = addr[INDEX_BITS+1:2];
   assign addr_tag         = addr[ADDR_BITS-1:INDEX_BITS+2];
   assign unused_addr_bits = ^addr[1:0];

   // Array write happens on the same edge that raises Read_ready for a refill,
   // so a clr seen in that cycle suppresses both the write and the response.
   assign wr_en = rdy & fill_done;

   icache_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .rd_index_i (addr_index),
      .rd_valid_o (line_valid),
      .rd_tag_o   (line_tag),
      .rd_data_o  (line_data),
      .wr_en_i    (wr_en),
      .wr_index_i (req_index_q),
      .wr_tag_i   (req_tag_q),
      .wr_data_i  (assembled)
   );

   assign hit = line_valid && (line_tag == addr_tag);

   // Word including the byte arriving this cycle; on the last beat it is the
   // complete line.
   assign assembled = insert_byte(fill_word_q, beat_q, mem_din);

   always_comb begin
      state_d      = state_q;
      inst_d       = inst_q;
      read_ready_d = FALSE;
      mem_a_d      = mem_a_q;
      mem_rn_d     = mem_rn_q;
      beat_d       = beat_q;
      fill_word_d  = fill_word_q;
      req_index_d  = req_index_q;
      req_tag_d    = req_tag_q;
      fill_done    = FALSE;

      unique case (state_q)
         ST_IDLE: begin
            if (rn) begin
               if (hit) begin
                  inst_d       = line_data;
                  read_ready_d = TRUE;
                  state_d      = ST_RESP;
               end else begin
                  req_index_d = addr_index;
                  req_tag_d   = addr_tag;
                  mem_a_d     = {addr[31:2], 2'b00};
                  mem_rn_d    = TRUE;
                  beat_d      = '0;
                  state_d     = ST_FILL;
               end
            end
         end

         ST_FILL: begin
            if (mem_valid) begin
               fill_word_d = assembled;
               beat_d      = beat_q + 1'b1;
               mem_a_d     = mem_a_q + 32'd1;
               if (beat_q == 2'd3) begin
                  fill_done    = TRUE;
                  mem_rn_d     = FALSE;
                  inst_d       = assembled;
                  read_ready_d = TRUE;
                  state_d      = ST_RESP;
               end
            end
         end

         // The fetcher still holds rn here (it drops it a cycle late), so rn
         // is deliberately not looked at.
         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Abort: everything the request started is dropped; the array and the
      // last delivered Inst are left alone.
      if (clr) begin
         state_d      = ST_IDLE;
         inst_d       = inst_q;
         read_ready_d = FALSE;
         mem_rn_d     = FALSE;
         mem_a_d      = mem_a_q;
         beat_d       = '0;
         fill_word_d  = fill_word_q;
         fill_done    = FALSE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         inst_q       <= '0;
         read_ready_q <= FALSE;
         mem_a_q      <= '0;
         mem_rn_q     <= FALSE;
         beat_q       <= '0;
         fill_word_q  <= '0;
         req_index_q  <= '0;
         req_tag_q    <= '0;
      end else if (rdy) begin
         state_q      <= state_d;
         inst_q       <= inst_d;
         read_ready_q <= read_ready_d;
         mem_a_q      <= mem_a_d;
         mem_rn_q     <= mem_rn_d;
         beat_q       <= beat_d;
         fill_word_q  <= fill_word_d;
         req_index_q  <= req_index_d;
         req_tag_q    <= req_tag_d;
      end
   end

   assign Inst       = inst_q;
   assign Read_ready = read_ready_q;
   assign mem_a      = mem_a_q;
   assign mem_rn     = mem_rn_q;

endmodule

// File: tb/tb_icache.sv
// -----------------------------------------------------------------------------
// tb_icache
//   Randomized scoreboard bench for the instruction cache. A fetcher task
//   issues requests and pushes the expected word; a negedge monitor pops and
//   compares on every accepted Read_ready pulse. The reference model is a
//   plain per-index table of (valid, tag, word) plus a fixed byte memory.
// -----------------------------------------------------------------------------
module tb_icache;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic        clr = 1'b0;
   logic [31:0] addr = '0;
   logic        rn = 1'b0;
   logic [31:0] Inst;
   logic        Read_ready;
   logic [31:0] mem_a;
   logic        mem_rn;
   logic [7:0]  mem_din = '0;
   logic        mem_valid = 1'b0;

   always #5 clk = ~clk;

   icache dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .clr        (clr),
      .addr       (addr),
      .rn         (rn),
      .Inst       (Inst),
      .Read_ready (Read_ready),
      .mem_a      (mem_a),
      .mem_rn     (mem_rn),
      .mem_din    (mem_din),
      .mem_valid  (mem_valid)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_resp = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;

   bit          m_valid [64];
   logic [9:0]  m_tag   [64];
   logic [31:0] m_data  [64];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   // Byte memory behind the controller; 0x4..0x7 hold 13,00,00,00.
   function automatic logic [7:0] mb(input logic [31:0] a);
      logic [31:0] h;
      if (a >= 32'd4 && a <= 32'd7) return (a == 32'd4) ? 8'h13 : 8'h00;
      h = a * 32'h9E37_79B1;
      return h[31:24] ^ h[7:0];
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] base;
      base = {a[31:2], 2'b00};
      return {mb(base + 32'd3), mb(base + 32'd2), mb(base + 32'd1), mb(base)};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
   endtask

   // Monitor: a pulse counts when rdy lets the fetcher take it.
   always @(negedge clk) begin
      if (rst && rdy && Read_ready) begin
         chk("pending_at_pulse", 32'(exp_q.size()), 32'd1);
         if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            chk("inst", Inst, mon_exp);
            n_resp++;
            $display("resp %0d: Inst=0x%08h expected=0x%08h", n_resp, Inst, mon_exp);
         end
      end
   end

   // One fetch transaction. Entered and left just after a rising edge.
   //   clr_cyc   : cycle (0 = issue cycle) to assert clr, -1 none
   //   clr_beat  : assert clr in a fill cycle once this many beats arrived, -1 none
   //   rst_beat  : pulse rst low once this many beats arrived, -1 none
   //   stall_mode: 0 rdy=1, 1 random rdy, 2 rdy=0 for 3 cycles after beat 1
   //   hold_rn   : keep rn high during the response cycle
   task automatic do_fetch(input logic [31:0] a, input int clr_cyc, input int clr_beat,
                           input int rst_beat, input int stall_mode, input bit hold_rn);
      int         idx, beats, active, fourth_active, stall_left;
      bit         pred_hit, saw_miss;
      logic [9:0] tg;
      idx      = int'(a[7:2]);
      tg       = a[17:8];
      pred_hit = m_valid[idx] && (m_tag[idx] == tg);
      exp_q.push_back(pred_hit ? m_data[idx] : mem_word(a));
      beats = 0; active = 0; fourth_active = -1; stall_left = 0; saw_miss = 1'b0;
      addr = a;
      rn   = 1'b1;
      for (int cyc = 0; cyc <= 300; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk);
            #1;
         end
         if (mem_rn) saw_miss = 1'b1;
         if (rst_beat >= 0 && mem_rn && beats == rst_beat) begin
            rst = 1'b0;
            #1;
            chk("rst_mem_rn", 32'(mem_rn), 32'd0);
            chk("rst_read_ready", 32'(Read_ready), 32'd0);
            chk("rst_inst", Inst, 32'd0);
            exp_q.delete();
            model_clear();
            rn = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b1;
            return;
         end
         rdy = (stall_mode == 1) ? ($urandom_range(0, 4) != 0) : 1'b1;
         if (stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
         end
         clr = 1'b0;
         if (cyc == clr_cyc || (clr_beat >= 0 && mem_rn && beats == clr_beat)) begin
            clr = 1'b1;
            rdy = 1'b1;
         end
         mem_valid = ($urandom_range(0, 3) != 0);
         mem_din   = mb(mem_a);
         if (Read_ready && rdy) begin
            if (pred_hit) chk("hit_latency", 32'(active), 32'd1);
            else          chk("miss_latency", 32'(active), 32'(fourth_active));
            chk("miss_seen", 32'(saw_miss), 32'(!pred_hit));
            chk("mem_rn_at_resp", 32'(mem_rn), 32'd0);
            if (!pred_hit) begin
               m_valid[idx] = 1'b1;
               m_tag[idx]   = tg;
               m_data[idx]  = mem_word(a);
            end
            rn = hold_rn;
            @(posedge clk);
            #1;
            chk("single_pulse", 32'(Read_ready), 32'd0);
            rn = 1'b0; clr = 1'b0; rdy = 1'b1;
            return;
         end else if (clr) begin
            exp_q.delete();
            @(posedge clk);
            #1;
            chk("mem_rn_after_clr", 32'(mem_rn), 32'd0);
            chk("ready_after_clr", 32'(Read_ready), 32'd0);
            rn = 1'b0; clr = 1'b0; rdy = 1'b1;
            return;
         end
         if (rdy) active++;
         if (rdy && mem_rn && mem_valid) begin
            beats++;
            if (beats == 4) fourth_active = active;
            if (beats == 1 && stall_mode == 2) stall_left = 3;
         end
      end
      n_cmp++;
      n_bad++;
      $display("FAIL request_timeout: addr 0x%08h got no response within 300 cycles", a);
      exp_q.delete();
      clr = 1'b1; rdy = 1'b1; rn = 1'b0;
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra;
      int          rc;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_read_ready", 32'(Read_ready), 32'd0);
      chk("reset_mem_rn", 32'(mem_rn), 32'd0);
      chk("reset_inst", Inst, 32'd0);
      chk("reset_mem_a", mem_a, 32'd0);

      // Directed scenarios
      do_fetch(32'h0000_0000, -1, -1, -1, 0, 1'b0); // cold miss
      do_fetch(32'h0000_0004, -1, -1, -1, 0, 1'b0); // miss -> 0x13
      do_fetch(32'h0000_0004, -1, -1, -1, 0, 1'b0); // hit
      do_fetch(32'h0000_0100, -1, -1, -1, 0, 1'b0); // conflict miss, index 0
      do_fetch(32'h0000_0000, -1, -1, -1, 0, 1'b0); // evicted -> miss
      do_fetch(32'h0000_0008, -1,  2, -1, 0, 1'b0); // clr after 2 beats
      do_fetch(32'h0000_0008, -1, -1, -1, 0, 1'b0); // full refill
      do_fetch(32'h0000_0004, -1, -1, -1, 0, 1'b1); // hit with rn held
      do_fetch(32'h0000_000C, -1, -1, -1, 2, 1'b0); // rdy stall after beat 1
      do_fetch(32'h0000_0004,  0, -1, -1, 0, 1'b0); // clr together with hit
      do_fetch(32'h0000_0004, -1, -1, -1, 0, 1'b0); // still a hit
      do_fetch(32'h0000_0014, -1,  3, -1, 0, 1'b0); // clr at last beat
      do_fetch(32'h0000_0014, -1, -1, -1, 0, 1'b0); // not written -> miss
      do_fetch(32'h0000_0010, -1, -1,  2, 0, 1'b0); // reset mid-fill
      do_fetch(32'h0000_0004, -1, -1, -1, 0, 1'b0); // invalidated -> miss

      // Random traffic over a small address pool to mix hits, conflicts,
      // aliases in the ignored upper bits, stalls and aborts.
      for (int n = 0; n < 300; n++) begin
         ra = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) ra = ra | ($urandom_range(1, 255) << 18);
         rc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8)) : -1;
         do_fetch(ra, rc, -1, -1, 1, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end

      repeat (5) @(posedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
